// File: rtl/mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the multi-cycle data-memory controller:
//   - state_t : controller FSM encoding (IDLE/ISSUE/WAIT/DONE, 2 bits)
//   - op_t    : captured access kind (load/store)
//   - DEFAULT_TIMEOUT / DEFAULT_ADDR_W / DEFAULT_DATA_W : parameter defaults
// No ports (package).
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_t;

    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_ADDR_W  = 16;
    localparam int DEFAULT_DATA_W  = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// ----------------------------------------------------------------------------
// mem_timeout_cnt
// Wait-cycle counter for the memory controller. Counts enabled cycles from 0
// and flags expire while the count sits at TIMEOUT-1.
// Ports:
//   clk     in  clock
//   rst     in  synchronous reset, active-low
//   clear   in  force count back to 0 (takes priority over enable)
//   enable  in  advance the count this cycle
//   expire  out count has reached TIMEOUT-1 (combinational from count)
// ----------------------------------------------------------------------------
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // NOTE: reset is sampled on the clock edge only (synchronous), so it sits
    // inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stall_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stall_ctrl
// Multi-cycle data-memory controller between the processor MEM stage and a
// variable-latency memory with a ready handshake. Each load/store is
// registered, presented to memory as a one-cycle strobe, and the pipeline is
// stalled until the memory answers (or the wait times out).
//
// Optional feature: define MEM_STALL_CTRL_RDBUF_EN to add a one-entry read
// buffer that answers a repeated load in the accepting cycle without stalling.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   req_rd / req_wr       load / store request, held until done
//   req_addr / req_wdata  access address / store data
//   rdata                 load data, valid with done
//   stall                 freeze PC/pipeline this cycle
//   done                  one-cycle completion pulse
//   err                   sticky error (conflict, misaligned, timeout)
//   mem_rd / mem_wr       one-cycle memory strobes
//   mem_addr / mem_wdata  registered address / write data to memory
//   mem_rdata / mem_ready memory read data and completion
// ----------------------------------------------------------------------------
module mem_stall_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            state;
    op_t               op;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              expire;

    logic              req_one;
    logic              req_both;
    logic              req_misalign;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_rdata;

    assign req_one      = req_rd ^ req_wr;
    assign req_both     = req_rd & req_wr;
    assign req_misalign = req_one & req_addr[0];

`ifdef MEM_STALL_CTRL_RDBUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              err_event;

    assign buf_hit   = (state == ST_IDLE) && req_rd && !req_wr && buf_valid
                       && (req_addr == buf_addr);
    assign buf_rdata = buf_data;
    assign err_event = ((state == ST_IDLE) && !buf_hit && (req_both || req_misalign))
                       || ((state == ST_WAIT) && !mem_ready && expire);

    // Loads fill the entry on completion; a completing store to the buffered
    // address keeps it coherent. Any error invalidates it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (err_event) begin
            buf_valid <= 1'b0;
        end else if ((state == ST_WAIT) && mem_ready) begin
            if (op == OP_LOAD) begin
                buf_valid <= 1'b1;
                buf_addr  <= mem_addr;
                buf_data  <= mem_rdata;
            end else if (buf_valid && (mem_addr == buf_addr)) begin
                buf_data  <= mem_wdata;
            end
        end
    end
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    // Stall is combinational in IDLE so the accepting cycle already freezes the
    // pipeline; a buffer hit completes in place and must not stall.
    assign stall = ((state == ST_IDLE) && (req_rd || req_wr) && !buf_hit)
                   || (state == ST_ISSUE) || (state == ST_WAIT);

    assign rdata = buf_hit ? buf_rdata : rdata_q;
    assign done  = done_q | buf_hit;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_WAIT),
        .enable (state == ST_WAIT),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op        <= OP_LOAD;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: pulse outputs get a default here and are overridden below;
            // non-blocking assignment makes the last write in the block win.
            done_q <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (buf_hit) begin
                        rdata_q <= buf_rdata;
                    end else if (req_both) begin
                        err    <= 1'b1;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (req_misalign) begin
                        err     <= 1'b1;
                        rdata_q <= '0;
                        done_q  <= 1'b1;
                        state   <= ST_DONE;
                    end else if (req_one) begin
                        op        <= req_wr ? OP_STORE : OP_LOAD;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        mem_rd    <= req_rd;
                        mem_wr    <= req_wr;
                        state     <= ST_ISSUE;
                    end
                end
                // mem_ready during ISSUE is deliberately ignored.
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_ready) begin
                        if (op == OP_LOAD) begin
                            rdata_q <= mem_rdata;
                        end
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (expire) begin
                        err     <= 1'b1;
                        rdata_q <= '0;
                        done_q  <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                // The processor still presents the same request here; ignore it.
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_stall_ctrl
// Scoreboard bench for mem_stall_ctrl (TIMEOUT=8). Stimulus pushes the
// expected completion of each access; a monitor pops it on every done pulse
// and compares stall cycles, strobe counts, address/data, rdata and err.
// A simple memory responder raises mem_ready a set number of cycles after a
// strobe. Read-buffer vectors run when MEM_STALL_CTRL_RDBUF_EN is defined.
// ----------------------------------------------------------------------------
module tb_mem_stall_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_rd, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] rdata;
    logic          stall, done, err;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    typedef struct {
        string         name;
        int            stalls;
        int            rds;
        int            wrs;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            chk_rdata;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            resp_delay = -1;
    logic [DW-1:0] resp_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk(input string n, input int s, input int r, input int w,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input bit cr, input logic [DW-1:0] rd, input logic er);
        exp_t e;
        e.name = n; e.stalls = s; e.rds = r; e.wrs = w; e.addr = a; e.wdata = wd;
        e.chk_rdata = cr; e.rdata = rd; e.err = er;
        return e;
    endfunction

    // Memory responder: mem_ready for one cycle, resp_delay cycles after a strobe.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst && (mem_rd || mem_wr) && resp_delay >= 0) begin
                for (int i = 0; i < resp_delay; i++) @(negedge clk);
                mem_ready = 1'b1;
                mem_rdata = resp_data;
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: accumulate per-access observations, compare on done.
    initial begin
        int            st_cnt = 0;
        int            rd_cnt = 0;
        int            wr_cnt = 0;
        logic [AW-1:0] seen_addr  = '0;
        logic [DW-1:0] seen_wdata = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                st_cnt = 0; rd_cnt = 0; wr_cnt = 0;
            end else begin
                if (stall) st_cnt++;
                if (mem_rd) begin rd_cnt++; seen_addr = mem_addr; end
                if (mem_wr) begin wr_cnt++; seen_addr = mem_addr; seen_wdata = mem_wdata; end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done_queue_size", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, ".stall_cycles"}, st_cnt, e.stalls);
                        check({e.name, ".mem_rd_pulses"}, rd_cnt, e.rds);
                        check({e.name, ".mem_wr_pulses"}, wr_cnt, e.wrs);
                        check({e.name, ".err"}, err, e.err);
                        if (e.rds + e.wrs > 0) check({e.name, ".mem_addr"}, seen_addr, e.addr);
                        if (e.wrs > 0) check({e.name, ".mem_wdata"}, seen_wdata, e.wdata);
                        if (e.chk_rdata) check({e.name, ".rdata"}, rdata, e.rdata);
                    end
                    st_cnt = 0; rd_cnt = 0; wr_cnt = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic do_access(input exp_t e, input logic rd, input logic wr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input int delay, input logic [DW-1:0] data);
        int n = 0;
        resp_delay = delay;
        resp_data  = data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
        #1;
        while (!done && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({e.name, ".done_within_budget"}, done, 1'b1);
        @(negedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        do_reset();
        check("reset.stall",     stall,     1'b0);
        check("reset.done",      done,      1'b0);
        check("reset.err",       err,       1'b0);
        check("reset.rdata",     rdata,     16'h0000);
        check("reset.mem_rd",    mem_rd,    1'b0);
        check("reset.mem_wr",    mem_wr,    1'b0);
        check("reset.mem_addr",  mem_addr,  16'h0000);
        check("reset.mem_wdata", mem_wdata, 16'h0000);

        // Load, ready two cycles after the strobe: 4 stall cycles.
        do_access(mk("load_0010", 4, 1, 0, 16'h0010, 16'h0, 1, 16'hBEEF, 1'b0),
                  1'b1, 1'b0, 16'h0010, 16'h0, 2, 16'hBEEF);
        // Store, ready one cycle after the strobe: 3 stall cycles, rdata unchanged.
        do_access(mk("store_0020", 3, 0, 1, 16'h0020, 16'h1234, 1, 16'hBEEF, 1'b0),
                  1'b0, 1'b1, 16'h0020, 16'h1234, 1, 16'h0);
        // Misaligned load: error, no strobe, done next cycle, rdata cleared.
        do_access(mk("load_misaligned", 1, 0, 0, 16'h0, 16'h0, 1, 16'h0000, 1'b1),
                  1'b1, 1'b0, 16'h0011, 16'h0, 1, 16'h0);
        repeat (3) @(posedge clk);
        #1 check("err_sticky_idle", err, 1'b1);
        // Load with three wait cycles while err stays high.
        do_access(mk("load_0012", 5, 1, 0, 16'h0012, 16'h0, 1, 16'h00C3, 1'b1),
                  1'b1, 1'b0, 16'h0012, 16'h0, 3, 16'h00C3);

        // Reset in WAIT abandons the access.
        resp_delay = -1;
        @(posedge clk); #1;
        req_rd = 1'b1; req_addr = 16'h0060;
        @(posedge clk); #1 check("abort.issue_strobe", mem_rd, 1'b1);
        @(posedge clk); #1 check("abort.wait_stall", stall, 1'b1);
        rst = 1'b0; req_rd = 1'b0;
        @(posedge clk); #1;
        check("abort.stall",  stall,  1'b0);
        check("abort.mem_rd", mem_rd, 1'b0);
        check("abort.err",    err,    1'b0);
        check("abort.rdata",  rdata,  16'h0000);
        check("abort.done",   done,   1'b0);
        rst = 1'b1;

        // Simultaneous load and store: error, no access.
        do_access(mk("rd_wr_conflict", 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1'b1),
                  1'b1, 1'b1, 16'h0070, 16'h5555, 1, 16'h0);
        do_reset();

        do_access(mk("load_0030", 3, 1, 0, 16'h0030, 16'h0, 1, 16'h3030, 1'b0),
                  1'b1, 1'b0, 16'h0030, 16'h0, 1, 16'h3030);
`ifdef MEM_STALL_CTRL_RDBUF_EN
        do_access(mk("rdbuf_hit_0030", 0, 0, 0, 16'h0, 16'h0, 1, 16'h3030, 1'b0),
                  1'b1, 1'b0, 16'h0030, 16'h0, 1, 16'hDEAD);
`endif
        // No mem_ready: 8 WAIT cycles then error completion.
        do_access(mk("timeout_0040", 10, 1, 0, 16'h0040, 16'h0, 1, 16'h0000, 1'b1),
                  1'b1, 1'b0, 16'h0040, 16'h0, -1, 16'h0);
        @(posedge clk); #1;
        check("timeout.idle_stall", stall, 1'b0);
        check("timeout.idle_done",  done,  1'b0);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
